hotsm_sbox_sequencer: RTL and testbench
=======================================

# hotsm_sbox_sequencer

Sequences a single shared first-order HO-TSM S-box datapath (phase-0 / subscript0 stage followed by phase-1 / subscript1 stage) across `NUM_LANES` byte lanes of one AES state. It produces the input, subscript0 and output register enables, the share-2 gate and the lane select. It enforces that share 2 reaches the datapath only after the subscript0 results are registered. It sits between the round controller (job handshake) and the randomness source (per-lane handshake).

## Interface
- `NUM_LANES`, 16, lanes per job; must be ≥ 2.
- `PH0_CYC`, 1, cycles spent in phase 0 per lane; must be ≥ 1.
- `PH1_CYC`, 1, cycles spent in phase 1 per lane; must be ≥ 1.
- `LW`, $clog2(NUM_LANES), lane-select width; derived, not overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  job request.
- `in_ready`  out  1  controller can accept a job.
- `rnd_valid`  in  1  fresh mask randomness is available for the current lane.
- `rnd_ack`  out  1  randomness consumed this cycle.
- `abort`  in  1  flush the current job.
- `lane_sel`  out  LW  lane currently routed through the datapath.
- `in_en`  out  1  load the lane's share-1/share-2 input registers.
- `sub0_en`  out  1  load the subscript0 registers.
- `share2_en`  out  1  pass share 2 into the datapath; when 0 the datapath forces share 2 to 0.
- `sub1_en`  out  1  write the phase-1 result for `lane_sel` into the state register.
- `out_valid`  out  1  job complete.
- `out_ready`  in  1  consumer accepts completion.
- `busy`  out  1  state ≠ IDLE.
- `state`  out  3  IDLE=0, LOAD=1, PH0=2, PH1=3, DONE=4 (debug).

## Operation
- The FSM has registered `state`, a lane counter (`LW` bits) and a phase counter (wide enough for max(PH0_CYC, PH1_CYC)).
- **IDLE:**
  - `in_ready`=1.
  - `in_valid` high → LOAD next cycle; lane counter := 0.
- **LOAD:**
  - Waits for `rnd_valid`.
  - When `rnd_valid` is high: `rnd_ack`=`in_en`=1 for that cycle, phase counter := 0, next state PH0.
  - When `rnd_valid` is low: stays in LOAD and all strobes are 0.
- **PH0:**
  - `share2_en`=0.
  - Phase counter increments each cycle.
  - On its last cycle (count = PH0_CYC−1): `sub0_en`=1, phase counter := 0, next state PH1.
- **PH1:**
  - `share2_en`=1 throughout.
  - On its last cycle (count = PH1_CYC−1): `sub1_en`=1.
  - If lane = NUM_LANES−1, next state DONE. Otherwise lane counter +1 and next state LOAD.
- **DONE:**
  - `out_valid`=1.
  - `out_ready` high → IDLE next cycle.
  - `in_valid` is ignored; there is no same-cycle restart.
- `share2_en` is 1 only in PH1. This is a security invariant and must hold in every state, including across abort and reset.
- `lane_sel` equals the lane counter in all states.
- **Abort:**
  - High in any state other than IDLE: `in_en`, `rnd_ack`, `sub0_en`, `sub1_en`, `share2_en` and `out_valid` are forced to 0 in that cycle.
  - Next state IDLE; lane and phase counters := 0.
  - Abort in IDLE has no effect and also blocks acceptance: `in_ready`=0 while `abort`=1.
- **Output logic:**
  - All strobes are a combinational decode of registered state/counters, gated by `abort`.
  - `rnd_ack` and `in_en` additionally depend on `rnd_valid`.
  - There are no other input-to-output paths.

## Timing
- **Reset (`rst_n`=0 at an edge):**
  - State IDLE; counters 0.
  - `in_ready`=1, and every other output is 0, from the following cycle onward.
  - Reset takes priority over `abort` and all handshakes.
  - A reset mid-job discards the job with no further strobes.
- **Latency:**
  - Job accepted at cycle t.
  - Lane k's `in_en` is at t+1+k·L+(randomness stall cycles), where L = 1+PH0_CYC+PH1_CYC.
  - With `rnd_valid` held high, `out_valid` first rises at t+1+NUM_LANES·L. Defaults: t+49.
- **Per-lane strobe offsets (relative to lane `in_en`):**
  - `sub0_en` at +PH0_CYC.
  - `share2_en` high from +PH0_CYC+1 to +PH0_CYC+PH1_CYC.
  - `sub1_en` at +PH0_CYC+PH1_CYC.
- `out_valid` holds until the `out_ready` cycle. IDLE is entered the cycle after that, so back-to-back jobs have one DONE→IDLE bubble.
- **Mutual exclusion:** `sub0_en` and `share2_en` are never high in the same cycle. `in_en` and `share2_en` are never high in the same cycle.
- **Wrap:** the lane counter never wraps. It stops at NUM_LANES−1 and returns to 0 only via IDLE, abort or reset.

## Test plan
- **Defaults, nominal job:** `rnd_valid`=1, `in_valid` pulse at t=10, `out_ready`=1.
  - 16 `in_en` pulses at t=11,14,…,56; `sub0_en` at t=12,15,…; `share2_en` at t=13,16,…; `sub1_en` at t=13,16,…
  - `lane_sel` 0..15 in step; `out_valid` at t=59; IDLE at t=60.
- **Randomness stall:** `rnd_valid` low for 5 cycles at lane 3's LOAD.
  - State stays LOAD with all strobes 0; lane 3 `in_en` is delayed by 5 cycles.
  - `out_valid` is delayed by exactly 5 cycles.
- **PH0_CYC=2, PH1_CYC=3, NUM_LANES=4:**
  - Per-lane period is 6 cycles.
  - `sub0_en` at +2, `share2_en` +3..+5, `sub1_en` at +5; `out_valid` at t+25.
- **Abort during PH1 of lane 7:**
  - All strobes are 0 in the abort cycle; IDLE next cycle with `lane_sel`=0.
  - A new job is accepted normally afterwards.
- **Backpressure and reset:**
  - `out_ready` low for 4 cycles keeps `out_valid`=1 and `in_ready`=0.
  - `rst_n`=0 during PH0 of lane 2 gives IDLE, `in_ready`=1, all other outputs 0 on the next cycle.
- **Invariant checker (whole run, including random abort/reset/stall):**
  - Assert `share2_en` → `state`==PH1.
  - Assert !(`sub0_en` & `share2_en`).

Source files
------------

// File: rtl/hotsm_sbox_sequencer.sv
// rtl/hotsm_sbox_sequencer.sv - lane/phase sequencer for a shared first-order HO-TSM S-box datapath
module hotsm_sbox_sequencer #(
  parameter int NUM_LANES = 16,
  parameter int PH0_CYC   = 1,
  parameter int PH1_CYC   = 1,
  localparam int LW       = $clog2(NUM_LANES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          rnd_valid,
  output logic          rnd_ack,
  input  logic          abort,
  output logic [LW-1:0] lane_sel,
  output logic          in_en,
  output logic          sub0_en,
  output logic          share2_en,
  output logic          sub1_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic [2:0]    state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PH0  = 3'd2;
  localparam logic [2:0] S_PH1  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Phase counter only has to reach the longer of the two phases.
  localparam int PMAX = (PH0_CYC > PH1_CYC) ? PH0_CYC : PH1_CYC;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [PW-1:0] PH0_LAST  = PW'(PH0_CYC - 1);
  localparam logic [PW-1:0] PH1_LAST  = PW'(PH1_CYC - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(NUM_LANES - 1);

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [PW-1:0] phase_q, phase_d;

  // Registered FSM state and counters; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic: abort outside IDLE flushes the job, otherwise walk LOAD->PH0->PH1 per lane.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    phase_d = phase_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      lane_d  = '0;
      phase_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && !abort) begin
            state_d = S_LOAD;
            lane_d  = '0;
            phase_d = '0;
          end
        end
        S_LOAD: begin
          if (rnd_valid) begin
            state_d = S_PH0;
            phase_d = '0;
          end
        end
        S_PH0: begin
          if (phase_q == PH0_LAST) begin
            state_d = S_PH1;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_PH1: begin
          if (phase_q == PH1_LAST) begin
            phase_d = '0;
            if (lane_q == LANE_LAST) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
              lane_d  = lane_q + LW'(1);
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        S_DONE: begin
          // in_valid is deliberately ignored here: no same-cycle restart.
          if (out_ready) begin
            state_d = S_IDLE;
            lane_d  = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
          lane_d  = '0;
          phase_d = '0;
        end
      endcase
    end
  end

  // Strobe decode from registered state; abort kills every strobe so share 2 can never leak.
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !abort;
    rnd_ack   = 1'b0;
    in_en     = 1'b0;
    sub0_en   = 1'b0;
    share2_en = 1'b0;
    sub1_en   = 1'b0;
    out_valid = 1'b0;
    if (!abort) begin
      case (state_q)
        S_LOAD: begin
          rnd_ack = rnd_valid;
          in_en   = rnd_valid;
        end
        S_PH0: begin
          sub0_en = (phase_q == PH0_LAST);
        end
        S_PH1: begin
          share2_en = 1'b1;
          sub1_en   = (phase_q == PH1_LAST);
        end
        S_DONE: begin
          out_valid = 1'b1;
        end
        default: begin
          rnd_ack = 1'b0;
        end
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign state    = state_q;
  assign lane_sel = lane_q;

endmodule

// File: tb/tb_hotsm_sbox_sequencer.sv
// tb/tb_hotsm_sbox_sequencer.sv - self-checking bench for hotsm_sbox_sequencer
module tb_hotsm_sbox_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid_a = 1'b0;
  logic in_valid_b = 1'b0;
  logic rnd_valid = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;

  logic a_in_ready, a_rnd_ack, a_in_en, a_sub0_en, a_share2_en, a_sub1_en, a_out_valid, a_busy;
  logic [3:0] a_lane_sel;
  logic [2:0] a_state;
  logic b_in_ready, b_rnd_ack, b_in_en, b_sub0_en, b_share2_en, b_sub1_en, b_out_valid, b_busy;
  logic [1:0] b_lane_sel;
  logic [2:0] b_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit sel_b = 1'b0;

  int q_in[$];
  int q_lane[$];
  int q_ack[$];
  int q_sub0[$];
  int q_sh2[$];
  int q_sub1[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  hotsm_sbox_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(a_in_ready),
    .rnd_valid(rnd_valid), .rnd_ack(a_rnd_ack), .abort(abort), .lane_sel(a_lane_sel),
    .in_en(a_in_en), .sub0_en(a_sub0_en), .share2_en(a_share2_en), .sub1_en(a_sub1_en),
    .out_valid(a_out_valid), .out_ready(out_ready), .busy(a_busy), .state(a_state)
  );

  hotsm_sbox_sequencer #(.NUM_LANES(4), .PH0_CYC(2), .PH1_CYC(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(b_in_ready),
    .rnd_valid(rnd_valid), .rnd_ack(b_rnd_ack), .abort(abort), .lane_sel(b_lane_sel),
    .in_en(b_in_en), .sub0_en(b_sub0_en), .share2_en(b_share2_en), .sub1_en(b_sub1_en),
    .out_valid(b_out_valid), .out_ready(out_ready), .busy(b_busy), .state(b_state)
  );

  logic m_in_en, m_rnd_ack, m_sub0, m_sh2, m_sub1, m_out_valid, m_in_ready;
  logic [3:0] m_lane;
  logic [2:0] m_state;
  assign m_in_en     = sel_b ? b_in_en : a_in_en;
  assign m_rnd_ack   = sel_b ? b_rnd_ack : a_rnd_ack;
  assign m_sub0      = sel_b ? b_sub0_en : a_sub0_en;
  assign m_sh2       = sel_b ? b_share2_en : a_share2_en;
  assign m_sub1      = sel_b ? b_sub1_en : a_sub1_en;
  assign m_out_valid = sel_b ? b_out_valid : a_out_valid;
  assign m_in_ready  = sel_b ? b_in_ready : a_in_ready;
  assign m_lane      = sel_b ? {2'b00, b_lane_sel} : a_lane_sel;
  assign m_state     = sel_b ? b_state : a_state;

  // Event log of the selected instance, stamped with the cycle number.
  always @(negedge clk) begin
    if (m_in_en) begin
      q_in.push_back(cyc);
      q_lane.push_back(int'(m_lane));
    end
    if (m_rnd_ack) q_ack.push_back(cyc);
    if (m_sub0) q_sub0.push_back(cyc);
    if (m_sh2) q_sh2.push_back(cyc);
    if (m_sub1) q_sub1.push_back(cyc);
  end

  // Security invariants on both instances for the whole run.
  always @(negedge clk) begin
    if (chk_en) begin
      checks += 6;
      if (a_share2_en === 1'b1 && a_state !== 3'd3) begin
        errors++; $display("FAIL inv_a_share2_ph1: state=%0d share2=1 required state=3", a_state);
      end
      if (b_share2_en === 1'b1 && b_state !== 3'd3) begin
        errors++; $display("FAIL inv_b_share2_ph1: state=%0d share2=1 required state=3", b_state);
      end
      if ((a_sub0_en & a_share2_en) !== 1'b0) begin
        errors++; $display("FAIL inv_a_sub0_share2: got %b required 0", a_sub0_en & a_share2_en);
      end
      if ((b_sub0_en & b_share2_en) !== 1'b0) begin
        errors++; $display("FAIL inv_b_sub0_share2: got %b required 0", b_sub0_en & b_share2_en);
      end
      if ((a_in_en & a_share2_en) !== 1'b0) begin
        errors++; $display("FAIL inv_a_in_share2: got %b required 0", a_in_en & a_share2_en);
      end
      if ((b_in_en & b_share2_en) !== 1'b0) begin
        errors++; $display("FAIL inv_b_in_share2: got %b required 0", b_in_en & b_share2_en);
      end
    end
  end

  task automatic clear_logs;
    q_in.delete(); q_lane.delete(); q_ack.delete();
    q_sub0.delete(); q_sh2.delete(); q_sub1.delete();
  endtask

  // One full job; expected timing computed from the lane period and the stall window.
  task automatic run_job(input bit use_b, input int n, input int ph0, input int ph1,
                         input int st_lane, input int st_len, input int hold, input string nm);
    int L, t, ws, c_out, e;
    bit seen;
    L = 1 + ph0 + ph1;
    @(posedge clk); #1;
    sel_b = use_b;
    clear_logs();
    t = cyc;
    ws = t + 1 + st_lane * L;
    c_out = -1;
    seen = 1'b0;
    if (use_b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    out_ready = (hold == 0);
    for (int k = 0; k < 600; k++) begin
      rnd_valid = (st_len == 0) || (cyc < ws) || (cyc >= ws + st_len);
      @(negedge clk);
      if (m_out_valid === 1'b1) begin
        seen = 1'b1;
        c_out = cyc;
        break;
      end
      @(posedge clk); #1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
    end
    rnd_valid = 1'b1;
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s_timeout: out_valid not seen within 600 cycles", nm);
    end else begin
      checks++;
      if (c_out != t + 1 + n * L + st_len) begin
        errors++; $display("FAIL %s_out_valid_cycle: got %0d required %0d", nm, c_out - t, 1 + n * L + st_len);
      end
      for (int h = 0; h < hold; h++) begin
        if (h > 0) begin
          @(posedge clk); #1;
          if (use_b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
          @(negedge clk);
        end
        checks++;
        if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0 || m_state !== 3'd4) begin
          errors++;
          $display("FAIL %s_hold%0d: out_valid=%b in_ready=%b state=%0d required 1 0 4", nm, h, m_out_valid, m_in_ready, m_state);
        end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (hold > 0) begin
        if (use_b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
      end
      @(posedge clk); #1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      @(negedge clk);
      checks++;
      if (m_state !== 3'd0 || m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_lane !== 4'd0) begin
        errors++;
        $display("FAIL %s_back_idle: state=%0d in_ready=%b out_valid=%b lane=%0d required 0 1 0 0", nm, m_state, m_in_ready, m_out_valid, m_lane);
      end
    end
    checks += 4;
    if (q_in.size() != n) begin
      errors++; $display("FAIL %s_in_en_count: got %0d required %0d", nm, q_in.size(), n);
    end
    if (q_ack.size() != n) begin
      errors++; $display("FAIL %s_rnd_ack_count: got %0d required %0d", nm, q_ack.size(), n);
    end
    if (q_sub0.size() != n || q_sub1.size() != n) begin
      errors++; $display("FAIL %s_sub_counts: sub0=%0d sub1=%0d required %0d", nm, q_sub0.size(), q_sub1.size(), n);
    end
    if (q_sh2.size() != n * ph1) begin
      errors++; $display("FAIL %s_share2_count: got %0d required %0d", nm, q_sh2.size(), n * ph1);
    end
    for (int j = 0; j < n; j++) begin
      e = t + 1 + j * L + ((j >= st_lane) ? st_len : 0);
      if (j < q_in.size()) begin
        checks += 2;
        if (q_in[j] != e) begin
          errors++; $display("FAIL %s_in_en_lane%0d: got %0d required %0d", nm, j, q_in[j] - t, e - t);
        end
        if (q_lane[j] != j) begin
          errors++; $display("FAIL %s_lane_sel%0d: got %0d required %0d", nm, j, q_lane[j], j);
        end
      end
      if (j < q_ack.size()) begin
        checks++;
        if (q_ack[j] != e) begin
          errors++; $display("FAIL %s_rnd_ack_lane%0d: got %0d required %0d", nm, j, q_ack[j] - t, e - t);
        end
      end
      if (j < q_sub0.size()) begin
        checks++;
        if (q_sub0[j] != e + ph0) begin
          errors++; $display("FAIL %s_sub0_lane%0d: got %0d required %0d", nm, j, q_sub0[j] - t, e + ph0 - t);
        end
      end
      if (j < q_sub1.size()) begin
        checks++;
        if (q_sub1[j] != e + ph0 + ph1) begin
          errors++; $display("FAIL %s_sub1_lane%0d: got %0d required %0d", nm, j, q_sub1[j] - t, e + ph0 + ph1 - t);
        end
      end
      for (int i = 0; i < ph1; i++) begin
        if (j * ph1 + i < q_sh2.size()) begin
          checks++;
          if (q_sh2[j * ph1 + i] != e + ph0 + 1 + i) begin
            errors++; $display("FAIL %s_share2_lane%0d_%0d: got %0d required %0d", nm, j, i, q_sh2[j * ph1 + i] - t, e + ph0 + 1 + i - t);
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid_a = 1'b1;
    in_valid_b = 1'b1;
    rnd_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    checks += 2;
    if ({a_state, a_in_ready, a_rnd_ack, a_in_en, a_sub0_en, a_share2_en, a_sub1_en, a_out_valid, a_busy, a_lane_sel} !== {3'd0, 1'b1, 7'd0, 4'd0}) begin
      errors++; $display("FAIL reset_a: state=%0d in_ready=%b busy=%b lane=%0d required 0 1 0 0", a_state, a_in_ready, a_busy, a_lane_sel);
    end
    if ({b_state, b_in_ready, b_rnd_ack, b_in_en, b_sub0_en, b_share2_en, b_sub1_en, b_out_valid, b_busy, b_lane_sel} !== {3'd0, 1'b1, 7'd0, 2'd0}) begin
      errors++; $display("FAIL reset_b: state=%0d in_ready=%b busy=%b lane=%0d required 0 1 0 0", b_state, b_in_ready, b_busy, b_lane_sel);
    end
  endtask

  task automatic test_nominal;
    run_job(1'b0, 16, 1, 1, 16, 0, 0, "nominal");
  endtask

  task automatic test_stall;
    run_job(1'b0, 16, 1, 1, 3, 5, 0, "stall_l3");
    run_job(1'b0, 16, 1, 1, int'($urandom_range(0, 15)), int'($urandom_range(1, 9)), 0, "stall_rand");
  endtask

  task automatic test_params;
    run_job(1'b1, 4, 2, 3, 4, 0, 0, "p4_2_3");
    run_job(1'b1, 4, 2, 3, int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 0, "p4_2_3_stall");
    sel_b = 1'b0;
  endtask

  task automatic test_abort;
    int t;
    sel_b = 1'b0;
    @(posedge clk); #1;
    t = cyc;
    in_valid_a = 1'b1;
    rnd_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    while (cyc < t + 24) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(negedge clk);
    checks += 2;
    if (a_state !== 3'd3 || a_lane_sel !== 4'd7) begin
      errors++; $display("FAIL abort_where: state=%0d lane=%0d required 3 7", a_state, a_lane_sel);
    end
    if ({a_in_en, a_rnd_ack, a_sub0_en, a_share2_en, a_sub1_en, a_out_valid, a_in_ready, a_busy} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL abort_strobes: got %b required 00000001", {a_in_en, a_rnd_ack, a_sub0_en, a_share2_en, a_sub1_en, a_out_valid, a_in_ready, a_busy});
    end
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (a_state !== 3'd0 || a_lane_sel !== 4'd0 || a_in_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle: state=%0d lane=%0d in_ready=%b busy=%b required 0 0 1 0", a_state, a_lane_sel, a_in_ready, a_busy);
    end
    @(posedge clk); #1;
    abort = 1'b1;
    in_valid_a = 1'b1;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_idle_ready: got %b required 0", a_in_ready);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid_a = 1'b0;
    @(negedge clk);
    checks++;
    if (a_state !== 3'd0) begin
      errors++; $display("FAIL abort_idle_no_accept: state=%0d required 0", a_state);
    end
    run_job(1'b0, 16, 1, 1, 16, 0, 0, "after_abort");
  endtask

  task automatic test_backpressure;
    run_job(1'b0, 16, 1, 1, 16, 0, 4, "backpressure");
  endtask

  task automatic test_reset_mid;
    int t;
    sel_b = 1'b0;
    @(posedge clk); #1;
    t = cyc;
    in_valid_a = 1'b1;
    rnd_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    while (cyc < t + 8) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (a_state !== 3'd2 || a_lane_sel !== 4'd2) begin
      errors++; $display("FAIL rst_mid_where: state=%0d lane=%0d required 2 2", a_state, a_lane_sel);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_state, a_in_ready, a_rnd_ack, a_in_en, a_sub0_en, a_share2_en, a_sub1_en, a_out_valid, a_busy, a_lane_sel} !== {3'd0, 1'b1, 7'd0, 4'd0}) begin
      errors++; $display("FAIL rst_mid_idle: state=%0d in_ready=%b busy=%b lane=%0d required 0 1 0 0", a_state, a_in_ready, a_busy, a_lane_sel);
    end
    clear_logs();
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (q_in.size() + q_sub0.size() + q_sh2.size() + q_sub1.size() != 0) begin
      errors++; $display("FAIL rst_mid_quiet: got %0d strobes required 0", q_in.size() + q_sub0.size() + q_sh2.size() + q_sub1.size());
    end
  endtask

  task automatic test_back_to_back;
    run_job(1'b0, 16, 1, 1, 16, 0, 0, "b2b_first");
    run_job(1'b0, 16, 1, 1, int'($urandom_range(0, 15)), int'($urandom_range(1, 8)), 0, "b2b_second");
  endtask

  task automatic test_random;
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      in_valid_a = ($urandom_range(0, 3) == 0);
      in_valid_b = ($urandom_range(0, 3) == 0);
      rnd_valid = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 40) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      rst_n = ($urandom_range(0, 80) != 0);
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    rst_n = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (a_state !== 3'd0 || b_state !== 3'd0 || a_share2_en !== 1'b0 || b_share2_en !== 1'b0) begin
      errors++; $display("FAIL random_flush: a_state=%0d b_state=%0d required 0 0", a_state, b_state);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_params();
    test_abort();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
